// File: rtl/mtm_alu_serializer.sv
// Transmit side of the mtm_Alu datapath: sends one ALU result (4 DATA frames + CTL frame) or one
// error report (single CTL frame) on the serial line sout, using the ALU input frame format.
module mtm_alu_serializer #(
  parameter int unsigned DATA_FRAMES = 4,
  parameter int unsigned FRAME_BITS  = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  input  logic [31:0] res_c,
  input  logic [3:0]  res_flags,
  input  logic        err_valid,
  input  logic [5:0]  err_flags,
  output logic        in_ready,
  output logic        sout
);

  typedef enum logic [1:0] {StIdle, StSendData, StSendCtl} state_e;

  localparam logic [3:0] LastBit   = 4'(FRAME_BITS - 1);
  localparam logic [1:0] LastFrame = 2'(DATA_FRAMES - 1);

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  frame_cnt_q, frame_cnt_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  ctl_q, ctl_d;

  logic        accept;
  logic        frame_end;
  logic [10:0] frame;
  logic [3:0]  bit_idx;

  // Serial CRC3 (x^3+x+1, init 0), evaluated MSB first over the whole vector in one cycle.
  function automatic logic [2:0] crc3(input logic [36:0] v);
    logic [2:0] c;
    logic       fb;
    c = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ v[i];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  assign accept    = in_ready & (res_valid | err_valid);
  assign frame_end = (bit_cnt_q == LastBit);
  assign bit_idx   = LastBit - bit_cnt_q;

  always_comb begin
    in_ready = (state_q == StIdle);
    frame    = '1;
    sout     = 1'b1;
    unique case (state_q)
      StSendData: frame = {1'b0, 1'b0, data_q[31:24], 1'b1};
      StSendCtl:  frame = {1'b0, 1'b1, ctl_q, 1'b1};
      default:    frame = '1;
    endcase
    if (state_q != StIdle) begin
      sout = frame[bit_idx];
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    data_d      = data_q;
    ctl_d       = ctl_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          bit_cnt_d   = 4'd0;
          frame_cnt_d = 2'd0;
          // Error report takes priority; a simultaneous result is dropped.
          if (err_valid) begin
            ctl_d   = {1'b1, err_flags, ^{1'b1, err_flags}};
            state_d = StSendCtl;
          end else begin
            data_d  = res_c;
            ctl_d   = {1'b0, res_flags, crc3({res_c, 1'b0, res_flags})};
            state_d = StSendData;
          end
        end
      end
      StSendData: begin
        if (frame_end) begin
          bit_cnt_d = 4'd0;
          data_d    = {data_q[23:0], 8'h00};
          if (frame_cnt_q == LastFrame) begin
            frame_cnt_d = 2'd0;
            state_d     = StSendCtl;
          end else begin
            frame_cnt_d = frame_cnt_q + 2'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      StSendCtl: begin
        if (frame_end) begin
          bit_cnt_d = 4'd0;
          state_d   = StIdle;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 4'd0;
      frame_cnt_q <= 2'd0;
      data_q      <= 32'd0;
      ctl_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      data_q      <= data_d;
      ctl_q       <= ctl_d;
    end
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed bench for mtm_alu_serializer: captures each 11-bit frame off sout and compares it with
// frames built from hand-computed payloads and a polynomial-division CRC model.
module tb_mtm_alu_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        res_valid;
  logic [31:0] res_c;
  logic [3:0]  res_flags;
  logic        err_valid;
  logic [5:0]  err_flags;
  logic        in_ready;
  logic        sout;

  int n_cmp = 0;
  int n_err = 0;

  mtm_alu_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_c     (res_c),
    .res_flags (res_flags),
    .err_valid (err_valid),
    .err_flags (err_flags),
    .in_ready  (in_ready),
    .sout      (sout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC as remainder of {c,0,f}*x^3 divided by x^3+x+1.
  function automatic logic [2:0] crc_model(input logic [31:0] c, input logic [3:0] f);
    logic [39:0] r;
    r = {c, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--) begin
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    end
    return r[2:0];
  endfunction

  function automatic logic [10:0] mk_frame(input logic typ, input logic [7:0] pl);
    return {1'b0, typ, pl, 1'b1};
  endfunction

  // Called with the first bit of a frame on sout (1 time unit after its edge).
  task automatic capture(input string tag, input logic [10:0] exp);
    logic [10:0] got;
    logic        rdy_seen;
    rdy_seen = 1'b0;
    for (int i = 0; i < 11; i++) begin
      got[10-i] = sout;
      rdy_seen  = rdy_seen | in_ready;
      @(posedge clk);
      #1;
    end
    check(tag, 64'(got), 64'(exp));
    check({tag, "_busy"}, 64'(rdy_seen), 64'd0);
  endtask

  task automatic accept_res(input logic [31:0] c, input logic [3:0] f);
    res_c     = c;
    res_flags = f;
    res_valid = 1'b1;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  task automatic capture_result(input string tag, input logic [31:0] c, input logic [3:0] f);
    capture({tag, "_d0"}, mk_frame(1'b0, c[31:24]));
    capture({tag, "_d1"}, mk_frame(1'b0, c[23:16]));
    capture({tag, "_d2"}, mk_frame(1'b0, c[15:8]));
    capture({tag, "_d3"}, mk_frame(1'b0, c[7:0]));
    capture({tag, "_ctl"}, mk_frame(1'b1, {1'b0, f, crc_model(c, f)}));
    check({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    check({tag, "_idle_after"}, 64'(sout), 64'd1);
  endtask

  initial begin
    logic idle_ok;
    rst_n     = 1'b0;
    res_valid = 1'b0;
    err_valid = 1'b0;
    res_c     = '0;
    res_flags = '0;
    err_flags = '0;

    // 1. reset
    #12;
    check("rst_sout", 64'(sout), 64'd1);
    check("rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle_ok = idle_ok & sout & in_ready;
      @(posedge clk);
      #1;
    end
    check("idle_20", 64'(idle_ok), 64'd1);

    // 2. all-zero result, literal frames
    accept_res(32'h0, 4'h0);
    capture("zero_d0", 11'b00_00000000_1);
    capture("zero_d1", 11'b00_00000000_1);
    capture("zero_d2", 11'b00_00000000_1);
    capture("zero_d3", 11'b00_00000000_1);
    capture("zero_ctl", 11'b01_00000000_1);
    check("zero_ready", 64'(in_ready), 64'd1);

    // 3. zero flag -> CRC 110; then DEADBEEF
    accept_res(32'h0, 4'b0010);
    capture("zf_d0", 11'b00_00000000_1);
    capture("zf_d1", 11'b00_00000000_1);
    capture("zf_d2", 11'b00_00000000_1);
    capture("zf_d3", 11'b00_00000000_1);
    capture("zf_ctl", 11'b01_00010110_1);
    @(posedge clk);
    #1;
    accept_res(32'hDEADBEEF, 4'b1001);
    capture("beef_d0", 11'b00_11011110_1);
    capture("beef_d1", 11'b00_10101101_1);
    capture("beef_d2", 11'b00_10111110_1);
    capture("beef_d3", 11'b00_11101111_1);
    capture("beef_ctl", mk_frame(1'b1, {1'b0, 4'b1001, crc_model(32'hDEADBEEF, 4'b1001)}));
    check("beef_ready", 64'(in_ready), 64'd1);

    // 4. error report, alone and together with a result
    err_flags = 6'b100100;
    err_valid = 1'b1;
    @(posedge clk);
    #1;
    err_valid = 1'b0;
    capture("err", 11'b01_11001001_1);
    check("err_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    res_c     = 32'h12345678;
    res_flags = 4'hF;
    res_valid = 1'b1;
    err_valid = 1'b1;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    err_valid = 1'b0;
    capture("both", 11'b01_11001001_1);
    check("both_ready", 64'(in_ready), 64'd1);
    check("both_idle", 64'(sout), 64'd1);

    // 5. reset in data frame 2, bit 5 (that bit is a 1 so the abort is visible)
    accept_res(32'hA5C3FF0F, 4'b0100);
    capture("abort_d0", mk_frame(1'b0, 8'hA5));
    capture("abort_d1", mk_frame(1'b0, 8'hC3));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
    end
    check("abort_pre_bit", 64'(sout), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_sout", 64'(sout), 64'd1);
    check("abort_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 64'(in_ready), 64'd1);
    accept_res(32'h0BADF00D, 4'b1010);
    capture_result("post_rst", 32'h0BADF00D, 4'b1010);

    // 6. res_valid held high, res_c changed mid-packet
    @(posedge clk);
    #1;
    res_c     = 32'h13572468;
    res_flags = 4'b0001;
    res_valid = 1'b1;
    @(posedge clk);
    #1;
    res_c     = 32'hFEDCBA98;
    res_flags = 4'b1100;
    capture_result("b2b_a", 32'h13572468, 4'b0001);
    @(posedge clk);
    #1;
    check("b2b_start", 64'(sout), 64'd0);
    check("b2b_busy", 64'(in_ready), 64'd0);
    res_c     = 32'h0;
    res_flags = 4'h0;
    capture({"b2b_b_d0"}, mk_frame(1'b0, 8'hFE));
    capture({"b2b_b_d1"}, mk_frame(1'b0, 8'hDC));
    capture({"b2b_b_d2"}, mk_frame(1'b0, 8'hBA));
    capture({"b2b_b_d3"}, mk_frame(1'b0, 8'h98));
    capture({"b2b_b_ctl"}, mk_frame(1'b1, {1'b0, 4'b1100, crc_model(32'hFEDCBA98, 4'b1100)}));
    res_valid = 1'b0;
    check("b2b_b_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    check("final_idle", 64'(sout), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
